// File: rtl/nes_pad_responder_if.sv
// nes_pad_responder_if: console-side pins and status of the NES pad responder
//   i_button_state : 8 button levels, 1 = pressed (A,B,Sel,Start,Up,Down,Left,Right)
//   i_data_latch   : console latch pin (asynchronous)
//   i_data_clock   : console clock pin (asynchronous)
//   o_serial_data  : controller data pin, 0 = pressed
//   o_latched      : one-cycle pulse when a snapshot is frozen
//   o_bit_index    : bits shifted since the snapshot, 0..8
//   o_busy         : read in progress (LATCH or SHIFT)
interface nes_pad_responder_if;
  logic [7:0] i_button_state;
  logic       i_data_latch;
  logic       i_data_clock;
  logic       o_serial_data;
  logic       o_latched;
  logic [3:0] o_bit_index;
  logic       o_busy;
  modport master(output i_button_state, i_data_latch, i_data_clock,
                 input o_serial_data, o_latched, o_bit_index, o_busy);
  modport slave(input i_button_state, i_data_latch, i_data_clock,
                output o_serial_data, o_latched, o_bit_index, o_busy);
endinterface

// File: rtl/nes_pad_responder.sv
// nes_pad_responder: 4021-style NES controller emulator with synchronised, glitch-filtered console pins
//   i_clk : system clock, all logic in this domain
//   i_rst : asynchronous active-low reset
//   bus   : slave side of nes_pad_responder_if (buttons, latch/clock pins, data pin and status)
module nes_pad_responder #(
  parameter int       SYNC_STAGES    = 2,
  parameter int       FILTER_CYCLES  = 4,
  parameter int       TIMEOUT_CYCLES = 27000,
  parameter bit       FILL_BIT       = 1'b0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  nes_pad_responder_if.slave bus
);
  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FMAX = FW'(FILTER_CYCLES - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LATCH, SHIFT, DONE} state_t;

  logic [1:0] w_pin;
  logic [1:0] w_rise;
  logic [1:0] w_fall;
  assign w_pin = {bus.i_data_clock, bus.i_data_latch};

  // channel 0 = latch, channel 1 = clock
  for (genvar g = 0; g < 2; g++) begin : g_in
    logic [SYNC_STAGES-1:0] r_sync;
    logic [FW-1:0]          r_cnt;
    logic                   r_filt;
    logic                   r_prev;
    always_ff @(posedge i_clk or negedge i_rst)
      if (!i_rst) begin
        r_sync <= '0;
        r_cnt  <= '0;
        r_filt <= 1'b0;
        r_prev <= 1'b0;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], w_pin[g]};
        r_prev <= r_filt;
        // a new level is accepted on its FILTER_CYCLES-th consecutive sample
        if (r_sync[SYNC_STAGES-1] == r_filt) r_cnt <= '0;
        else if (r_cnt == FMAX) begin
          r_filt <= r_sync[SYNC_STAGES-1];
          r_cnt  <= '0;
        end else r_cnt <= r_cnt + 1'b1;
      end
    assign w_rise[g] = r_filt & ~r_prev;
    assign w_fall[g] = ~r_filt & r_prev;
  end

  state_t        r_state;
  logic [7:0]    r_sr;
  logic          r_sd;
  logic          r_latched;
  logic [3:0]    r_idx;
  logic [TW-1:0] r_tcnt;
  logic [7:0]    w_shift;
  assign w_shift = {FILL_BIT, r_sr[7:1]};

  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) begin
      r_state   <= IDLE;
      r_sr      <= 8'hFF;
      r_sd      <= 1'b1;
      r_latched <= 1'b0;
      r_idx     <= '0;
      r_tcnt    <= '0;
    end else begin
      r_latched <= 1'b0;
      case (r_state)
        IDLE:
          if (w_rise[0]) begin
            r_state <= LATCH;
            r_sr    <= ~bus.i_button_state;
            r_sd    <= ~bus.i_button_state[0];
          end
        LATCH:
          if (w_fall[0]) begin
            r_state   <= SHIFT;
            r_latched <= 1'b1;
            r_idx     <= '0;
            r_tcnt    <= '0;
          end else begin
            r_sr <= ~bus.i_button_state;
            r_sd <= ~bus.i_button_state[0];
          end
        default:
          // latch wins over a simultaneous clock edge
          if (w_rise[0]) begin
            r_state <= LATCH;
            r_sr    <= ~bus.i_button_state;
            r_sd    <= ~bus.i_button_state[0];
            r_idx   <= '0;
            r_tcnt  <= '0;
          end else if (r_state == SHIFT && w_rise[1]) begin
            r_sr    <= w_shift;
            r_sd    <= w_shift[0];
            r_idx   <= r_idx + 1'b1;
            r_tcnt  <= '0;
            if (r_idx == 4'd7) r_state <= DONE;
          end else if (r_tcnt == TMAX) begin
            r_state <= IDLE;
            r_sr    <= 8'hFF;
            r_sd    <= 1'b1;
            r_idx   <= '0;
            r_tcnt  <= '0;
          end else r_tcnt <= r_tcnt + 1'b1;
      endcase
    end

  assign bus.o_serial_data = r_sd;
  assign bus.o_latched     = r_latched;
  assign bus.o_bit_index   = r_idx;
  assign bus.o_busy        = (r_state == LATCH) || (r_state == SHIFT);
endmodule

// File: doc/nes_pad_responder.md
NES_PAD_RESPONDER -- requirements
Module: nes_pad_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchroniser flops on each console input (min 2).
REQ-002 SHALL have parameter FILTER_CYCLES, default 4: consecutive equal synchronised samples needed to accept a level change (min 1).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 27000: cycles without an accepted clock edge in SHIFT before abandoning the read (1 ms at 27 MHz).
REQ-004 SHALL have parameter FILL_BIT, default 1'b0: line level driven after all 8 bits are shifted out.
REQ-005 SHALL have port i_clk, input, 1: system clock. One clock; all logic in this domain.
REQ-006 SHALL have port i_rst, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port i_button_state, input, 8: bit0 A, bit1 B, bit2 Select, bit3 Start, bit4 Up, bit5 Down, bit6 Left, bit7 Right; 1 = pressed.
REQ-008 SHALL have port i_data_latch, input, 1: console latch pin; asynchronous to i_clk.
REQ-009 SHALL have port i_data_clock, input, 1: console clock pin; asynchronous to i_clk.
REQ-010 SHALL have port o_serial_data, output, 1: controller data pin, registered; 0 = pressed.
REQ-011 SHALL have port o_latched, output, 1: one-cycle pulse when a snapshot is frozen.
REQ-012 SHALL have port o_bit_index, output, 4: bits shifted since the snapshot, 0..8.
REQ-013 SHALL have port o_busy, output, 1: high in LATCH or SHIFT.

Function
REQ-014 SHALL pass each console input through SYNC_STAGES flops, then a filter; the filtered level changes only after FILTER_CYCLES consecutive equal samples.
REQ-015 SHALL detect edges only on filtered signals; pin-to-o_serial_data latency SHALL be at most SYNC_STAGES+FILTER_CYCLES+2 cycles.
REQ-016 SHALL implement states IDLE, LATCH, SHIFT, DONE.
REQ-017 IDLE: o_serial_data=1, o_bit_index=0; filtered latch high -> LATCH.
REQ-018 LATCH: shift register reloads ~i_button_state every cycle; o_serial_data = shift register bit0 (transparent, as a 4021 in parallel mode); clock edges ignored.
REQ-019 LATCH, filtered latch falling edge: register frozen at its current value, o_latched pulses for 1 cycle, o_bit_index=0, -> SHIFT.
REQ-020 SHIFT, filtered clock rising edge: shift register shifts right with FILL_BIT entering bit7; o_bit_index increments; o_serial_data = new bit0.
REQ-021 SHIFT: the 8th rising edge sets o_bit_index=8 and -> DONE; o_serial_data = FILL_BIT.
REQ-022 DONE: further clock edges leave o_serial_data=FILL_BIT; o_bit_index saturates at 8.
REQ-023 In SHIFT or DONE, filtered latch rising edge -> LATCH immediately (reload; partial read abandoned, no error).
REQ-024 In SHIFT, TIMEOUT_CYCLES cycles without an accepted clock edge -> IDLE; the counter clears on every accepted edge and on entry to SHIFT.
REQ-025 DONE -> IDLE after TIMEOUT_CYCLES cycles without a latch rising edge.
REQ-026 A latch edge and a clock edge accepted in the same cycle: the latch edge has priority and the clock edge is discarded.
REQ-027 i_button_state changes during SHIFT/DONE SHALL NOT affect the frozen snapshot.
REQ-028 The timeout counter SHALL be sized to hold TIMEOUT_CYCLES without wrap-around.

Reset
REQ-029 While i_rst=0 (asynchronously): state IDLE, synchronisers and filters at 0, shift register 8'hFF, o_serial_data=1, o_latched=0, o_bit_index=0, o_busy=0, timeout counter 0.
REQ-030 Reset asserted mid-read SHALL abandon the read; after release the block SHALL act only on a fresh filtered latch rising edge, with no spurious o_latched.

Verification
REQ-031 Buttons 8'b0000_0101 (A, Select); latch 324 cycles high, then 8 clock pulses (162 high / 162 low) -> o_latched pulse once; bit stream before clock 1 and after clocks 1..8 = 0,1,0,1,1,1,1,1,FILL_BIT; o_bit_index ends at 8.
REQ-032 Latch pulse, 3 clock pulses, then new latch with buttons 8'h80 -> reload, stream restarts from bit0=1, Right reported as 0 on 8th bit.
REQ-033 Glitches of FILTER_CYCLES-1 cycles on i_data_clock during SHIFT -> no shift, o_bit_index unchanged.
REQ-034 Latch then no clock for TIMEOUT_CYCLES+1 cycles -> state IDLE, o_busy=0, o_serial_data=1.
REQ-035 i_rst pulsed low after 4 bits -> all outputs at reset values within the same cycle; next full read returns the correct pattern.
REQ-036 i_button_state toggled every cycle during SHIFT -> stream equals the snapshot frozen at the latch falling edge.
